hps_pio_irq: RTL and testbench

Parametrised Avalon-MM parallel I/O slave with per-bit interrupt generation for the HPS lightweight bridge. It replaces the single-bit level-only PIO with a DATA_WIDTH-bit port and an input synchroniser. Each bit can raise its interrupt on level or on a captured edge. Edge-capture bits are sticky and write-1-to-clear, and outputs can be set or cleared atomically.

---
 rtl/hps_pio_irq.sv | 147 ++++++++++++++
 tb/tb_hps_pio_irq.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_pio_irq.sv
// Avalon-MM parallel I/O slave with synchronised inputs and per-bit
// level or edge interrupts, sticky W1C edge capture and atomic set/clear.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   address[2:0]          word register address
//   chipselect, write_n   bus select and active-low write strobe
//   writedata[31:0]       write data (bits >= DATA_WIDTH ignored)
//   in_port[W-1:0]        external inputs, async to clk
//   readdata[31:0]        registered read data
//   out_port[W-1:0]       output data register
//   irq                   level interrupt request
module hps_pio_irq #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter logic [DATA_WIDTH-1:0] OUT_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] sin;
  logic [W-1:0] prev_q;
  logic         armed_q;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] mode_q, mode_d;
  logic [W-1:0] mask_q, mask_d;
  logic [W-1:0] edge_q, edge_d;
  logic [W-1:0] clr;
  logic [31:0]  rd_q, rd_d;
  logic [W-1:0] wdata;
  logic [W-1:0] rise, fall, ev;
  logic         wr;
  logic         wr_data, wr_mode, wr_mask;
  logic         wr_edge, wr_set, wr_clr;
  logic         unused_wd;

  assign wdata     = writedata[W-1:0];
  assign unused_wd = ^writedata;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sin = in_port;
    end else begin : g_sync
      logic [W-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
        end else begin
          sync_q[0] <= in_port;
          for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
        end
      end
      assign sin = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = sin & ~prev_q;
  assign fall = ~sin & prev_q;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign ev = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign ev = fall;
    end else begin : g_any
      assign ev = rise | fall;
    end
  endgenerate

  assign wr      = chipselect & ~write_n;
  assign wr_data = wr && (address == 3'd0);
  assign wr_mode = wr && (address == 3'd1);
  assign wr_mask = wr && (address == 3'd2);
  assign wr_edge = wr && (address == 3'd3);
  assign wr_set  = wr && (address == 3'd4);
  assign wr_clr  = wr && (address == 3'd5);

  always_comb begin
    out_d  = out_q;
    mode_d = mode_q;
    mask_d = mask_q;
    clr    = '0;
    unique case (1'b1)
      wr_data: out_d  = wdata;
      wr_mode: mode_d = wdata;
      wr_mask: mask_d = wdata;
      wr_edge: clr    = wdata;
      wr_set:  out_d  = out_q | wdata;
      wr_clr:  out_d  = out_q & ~wdata;
      default: ;
    endcase
  end

  // A fresh event beats a same-cycle clear; nothing is captured
  // until armed, so the reset value of prev cannot fake an edge.
  assign edge_d = (edge_q & ~clr) | (ev & {W{armed_q}});

  always_comb begin
    rd_d = '0;
    unique case (address)
      3'd0:    rd_d[W-1:0] = sin;
      3'd1:    rd_d[W-1:0] = mode_q;
      3'd2:    rd_d[W-1:0] = mask_q;
      3'd3:    rd_d[W-1:0] = edge_q;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
      out_q   <= OUT_RESET;
      mode_q  <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      rd_q    <= '0;
    end else begin
      prev_q  <= sin;
      armed_q <= 1'b1;
      out_q   <= out_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rd_q    <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign out_port = out_q;
  assign irq = |(mask_q & ((mode_q & edge_q) | (~mode_q & sin)));

endmodule

// File: tb/tb_hps_pio_irq.sv
// Directed bench for hps_pio_irq: three instances cover the default
// configuration plus the SYNC_STAGES/EDGE_TYPE sweep on a shared bus.
module tb_hps_pio_irq;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in0, in1, in2;
  logic [7:0]  out0, out1, out2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  int          errors;
  int          checks;

  // u0: default sync, rising edge, non-zero output reset
  hps_pio_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .OUT_RESET(8'h5A)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in0), .readdata(rd0),
    .out_port(out0), .irq(irq0)
  );

  // u1: no synchroniser, any edge
  hps_pio_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(0), .EDGE_TYPE(2), .OUT_RESET(8'h00)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in1), .readdata(rd1),
    .out_port(out1), .irq(irq1)
  );

  // u2: three-stage synchroniser, falling edge
  hps_pio_irq #(
    .DATA_WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(1), .OUT_RESET(8'h00)
  ) u2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in2), .readdata(rd2),
    .out_port(out2), .irq(irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in0 = 8'hFF; in1 = 8'hFF; in2 = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out0 !== 8'h5A) begin
      errors++; $display("FAIL reset_out0 got=%h exp=5a", out0);
    end
    checks++;
    if (rd0 !== 32'h0 || rd1 !== 32'h0) begin
      errors++; $display("FAIL reset_rd got=%h/%h exp=0", rd0, rd1);
    end
    checks++;
    if ({irq0, irq1, irq2} !== 3'b000) begin
      errors++;
      $display("FAIL reset_irq got=%b exp=000", {irq0, irq1, irq2});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    // u1 sees 0xFF combinationally against prev=0 on the arming edge
    rd(3'd3);
    checks++;
    if (rd1 !== 32'h0) begin
      errors++; $display("FAIL arm_no_capture got=%h exp=0", rd1);
    end
    checks++;
    if (rd2 !== 32'h0) begin
      errors++; $display("FAIL arm_fall_none got=%h exp=0", rd2);
    end
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00;
    repeat (6) @(posedge clk);
    wr(3'd3, 32'hFF);
    rd(3'd3);
    checks++;
    if ({rd0, rd1, rd2} !== 96'h0) begin
      errors++;
      $display("FAIL w1c_all got=%h/%h/%h exp=0", rd0, rd1, rd2);
    end
  endtask

  task automatic test_edge_capture();
    wr(3'd1, 32'h01);
    wr(3'd2, 32'h01);
    @(negedge clk);
    in0[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL edge_early got=%b exp=0", irq0);
    end
    @(posedge clk); #1;
    checks++;
    if (irq0 !== 1'b1) begin
      errors++; $display("FAIL edge_irq got=%b exp=1", irq0);
    end
    rd(3'd3);
    checks++;
    if (rd0 !== 32'h01) begin
      errors++; $display("FAIL edge_read got=%h exp=01", rd0);
    end
    wr(3'd3, 32'h01);
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL edge_w1c_irq got=%b exp=0", irq0);
    end
    @(posedge clk); #1;
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL edge_stays_clr got=%b exp=0", irq0);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    in0[3] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // the event lands on the same edge as this clear
    wr(3'd3, 32'h08);
    rd(3'd3);
    checks++;
    if (rd0 !== 32'h08) begin
      errors++; $display("FAIL set_wins got=%h exp=08", rd0);
    end
    wr(3'd3, 32'h08);
    rd(3'd3);
    checks++;
    if (rd0 !== 32'h00) begin
      errors++; $display("FAIL clr_after got=%h exp=00", rd0);
    end
  endtask

  task automatic test_level();
    wr(3'd1, 32'h00);
    wr(3'd2, 32'h80);
    @(negedge clk);
    in0[7] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL level_early got=%b exp=0", irq0);
    end
    @(posedge clk); #1;
    checks++;
    if (irq0 !== 1'b1) begin
      errors++; $display("FAIL level_high got=%b exp=1", irq0);
    end
    @(negedge clk);
    in0[7] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (irq0 !== 1'b1) begin
      errors++; $display("FAIL level_hold got=%b exp=1", irq0);
    end
    @(posedge clk); #1;
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL level_low got=%b exp=0", irq0);
    end
    wr(3'd2, 32'h00);
    in0 = 8'hFF;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL mask0_ff got=%b exp=0", irq0);
    end
    in0 = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (irq0 !== 1'b0) begin
      errors++; $display("FAIL mask0_00 got=%b exp=0", irq0);
    end
  endtask

  task automatic test_outputs();
    wr(3'd0, 32'hFFFF_FF0F);
    checks++;
    if (out0 !== 8'h0F) begin
      errors++; $display("FAIL out_data got=%h exp=0f", out0);
    end
    wr(3'd4, 32'h30);
    checks++;
    if (out0 !== 8'h3F) begin
      errors++; $display("FAIL out_set got=%h exp=3f", out0);
    end
    wr(3'd5, 32'h01);
    checks++;
    if (out0 !== 8'h3E) begin
      errors++; $display("FAIL out_clr got=%h exp=3e", out0);
    end
    in0 = 8'hC3;
    repeat (3) @(posedge clk);
    rd(3'd0);
    checks++;
    if (rd0 !== 32'h0000_00C3) begin
      errors++; $display("FAIL read_sin got=%h exp=000000c3", rd0);
    end
    wr(3'd1, 32'h5A);
    rd(3'd1);
    checks++;
    if (rd0 !== 32'h5A) begin
      errors++; $display("FAIL read_mode got=%h exp=5a", rd0);
    end
    wr(3'd1, 32'h00);
    for (int a = 4; a < 8; a++) begin
      rd(3'(a));
      checks++;
      if (rd0 !== 32'h0) begin
        errors++; $display("FAIL read_addr%0d got=%h exp=0", a, rd0);
      end
    end
  endtask

  task automatic test_sweep();
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'hFF);
    wr(3'd3, 32'hFF);
    // u1: combinational sin, capture on the first edge
    @(negedge clk);
    in1 = 8'h01;
    #1;
    checks++;
    if (irq1 !== 1'b0) begin
      errors++; $display("FAIL s0_rise_pre got=%b exp=0", irq1);
    end
    @(posedge clk); #1;
    checks++;
    if (irq1 !== 1'b1) begin
      errors++; $display("FAIL s0_rise got=%b exp=1", irq1);
    end
    wr(3'd3, 32'hFF);
    @(negedge clk);
    in1 = 8'h00;
    #1;
    checks++;
    if (irq1 !== 1'b0) begin
      errors++; $display("FAIL s0_fall_pre got=%b exp=0", irq1);
    end
    @(posedge clk); #1;
    checks++;
    if (irq1 !== 1'b1) begin
      errors++; $display("FAIL s0_fall got=%b exp=1", irq1);
    end
    // u2: rising ignored, falling after four edges
    in2 = 8'h01;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (irq2 !== 1'b0) begin
      errors++; $display("FAIL s3_rise_ign got=%b exp=0", irq2);
    end
    @(negedge clk);
    in2 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq2 !== 1'b0) begin
      errors++; $display("FAIL s3_fall_early got=%b exp=0", irq2);
    end
    @(posedge clk); #1;
    checks++;
    if (irq2 !== 1'b1) begin
      errors++; $display("FAIL s3_fall got=%b exp=1", irq2);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out0 !== 8'h5A || out1 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_out got=%h/%h exp=5a/00", out0, out1);
    end
    checks++;
    if ({irq0, irq1, irq2} !== 3'b000 || rd0 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_irq got=%b rd=%h exp=000 rd=0",
               {irq0, irq1, irq2}, rd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    address = 3'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = 32'h0;
    test_reset();
    test_edge_capture();
    test_simultaneous();
    test_level();
    test_outputs();
    test_sweep();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
